// File: rtl/stone_ram_arbiter_if.sv
// stone_ram_arbiter_if: requester-side and RAM-side signals of the stone RAM arbiter
interface stone_ram_arbiter_if;
  logic [2:0] req;
  logic [2:0] we;
  logic [11:0] addr;
  logic [95:0] wdata;
  logic [2:0] gnt;
  logic [2:0] rvalid;
  logic [31:0] rdata;
  logic busy;
  logic [3:0] ram_address;
  logic [31:0] ram_data;
  logic ram_wren;
  logic [31:0] ram_q;
  modport master (
    output req, we, addr, wdata, ram_q,
    input gnt, rvalid, rdata, busy, ram_address, ram_data, ram_wren
  );
  modport slave (
    input req, we, addr, wdata, ram_q,
    output gnt, rvalid, rdata, busy, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/stone_ram_arbiter.sv
// stone_ram_arbiter: sole owner of the 16x32 stone RAM, serialising loader/renderer/rope transactions; define STONE_ARB_RR_EN for round-robin priority
module stone_ram_arbiter #(
  parameter int RD_LAT = 2
) (
  input logic i_clk,
  input logic i_rst,
  stone_ram_arbiter_if.slave io_bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t r_state;
  logic [1:0] r_idx;
  logic [1:0] r_cnt;
  logic r_we;
  logic [3:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_rdata;
  logic [2:0] r_gnt;
  logic [2:0] r_rvalid;
  logic [1:0] w_win;
`ifdef STONE_ARB_RR_EN
  logic [1:0] r_last;
  logic [1:0] w_base;
  logic [2:0] w_j;
  // Rotating search starting just after the last granted port; smallest offset wins
  always_comb begin
    w_base = r_last == 2'd2 ? 2'd0 : r_last + 2'd1;
    w_win = w_base;
    w_j = '0;
    for (int k = 2; k >= 0; k--) begin
      w_j = 3'(w_base) + 3'(k);
      w_j = w_j >= 3'd3 ? w_j - 3'd3 : w_j;
      w_win = io_bus.req[w_j[1:0]] ? w_j[1:0] : w_win;
    end
  end
`else
  // Fixed priority: lower port number wins
  always_comb w_win = io_bus.req[0] ? 2'd0 : io_bus.req[1] ? 2'd1 : 2'd2;
`endif
  // Transaction sequencer: latch the winner in idle, drive the RAM for one cycle, then wait out the read latency
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_cnt <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_rdata <= '0;
      r_gnt <= '0;
      r_rvalid <= '0;
`ifdef STONE_ARB_RR_EN
      r_last <= 2'd2;
`endif
    end else begin
      r_gnt <= '0;
      r_rvalid <= '0;
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: if (|io_bus.req) begin
          r_idx <= w_win;
          r_we <= io_bus.we[w_win] & (w_win != 2'd1);
          r_addr <= io_bus.addr[{w_win, 2'b00} +: 4];
          r_data <= io_bus.wdata[{w_win, 5'b00000} +: 32];
          r_gnt <= 3'b001 << w_win;
          r_state <= S_ISSUE;
`ifdef STONE_ARB_RR_EN
          r_last <= w_win;
`endif
        end
        S_ISSUE: begin
          r_cnt <= 2'(RD_LAT - 1);
          r_state <= r_we ? S_IDLE : S_WAIT;
        end
        S_WAIT: if (r_cnt == 2'd0) begin
          r_rdata <= io_bus.ram_q;
          r_rvalid <= 3'b001 << r_idx;
          r_state <= S_IDLE;
        end else r_cnt <= r_cnt - 2'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign io_bus.gnt = r_gnt;
  assign io_bus.rvalid = r_rvalid;
  assign io_bus.rdata = r_rdata;
  assign io_bus.busy = r_state != S_IDLE;
  assign io_bus.ram_address = r_addr;
  assign io_bus.ram_data = r_data;
  assign io_bus.ram_wren = r_we & ~i_rst;
endmodule

// File: tb/tb_stone_ram_arbiter.sv
// tb_stone_ram_arbiter: directed and randomized transactions against a behavioural arbiter/RAM model
module tb_stone_ram_arbiter;
  localparam int RD_LAT = 2;
`ifdef STONE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req;
  logic [2:0] we;
  logic [3:0] a_ [3];
  logic [31:0] d_ [3];
  logic [31:0] mem [16];
  logic [31:0] p1;
  logic [31:0] q;
  logic [31:0] ref_mem [16];
  logic [31:0] last_rd = '0;
  int last = 2;
  int checks = 0;
  int fails = 0;
  stone_ram_arbiter_if bus();
  stone_ram_arbiter #(.RD_LAT(RD_LAT)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));
  assign bus.req = req;
  assign bus.we = we;
  assign bus.addr = {a_[2], a_[1], a_[0]};
  assign bus.wdata = {d_[2], d_[1], d_[0]};
  assign bus.ram_q = q;
  always #5 clk = ~clk;
  // Registered-output RAM with two cycles of read latency
  always_ff @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    p1 <= mem[bus.ram_address];
    q <= p1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] pick(input logic [2:0] r);
    int s = RR ? (last + 1) % 3 : 0;
    for (int k = 0; k < 3; k++) if (r[(s + k) % 3]) return 2'((s + k) % 3);
    return 2'd0;
  endfunction
  task automatic serve(input bit keep);
    int w;
    logic [1:0] p;
    logic [2:0] g;
    bit wr;
    logic [3:0] a;
    logic [31:0] d;
    p = pick(req);
    g = 3'b001 << p;
    wr = we[p] && p != 2'd1;
    a = a_[p];
    d = d_[p];
    w = 0;
    @(negedge clk);
    while (bus.gnt === 3'b000 && w < 8) begin
      w++;
      @(negedge clk);
    end
    chk("gnt_wait", w, 0);
    chk("gnt", bus.gnt, g);
    chk("issue_wren", bus.ram_wren, wr);
    chk("issue_addr", bus.ram_address, a);
    chk("issue_busy", bus.busy, 1);
    if (wr) begin
      chk("issue_data", bus.ram_data, d);
      ref_mem[a] = d;
    end
    last = p;
    if (!keep) req[p] = 1'b0;
    if (wr) begin
      @(negedge clk);
      chk("wr_busy_low", bus.busy, 0);
      chk("wr_no_rvalid", bus.rvalid, 0);
      chk("wr_wren_low", bus.ram_wren, 0);
      chk("rdata_held", bus.rdata, last_rd);
    end else begin
      repeat (RD_LAT) begin
        @(negedge clk);
        chk("wait_rvalid", bus.rvalid, 0);
        chk("wait_wren", bus.ram_wren, 0);
        chk("wait_addr", bus.ram_address, a);
      end
      @(negedge clk);
      chk("rvalid", bus.rvalid, g);
      chk("rdata", bus.rdata, ref_mem[a]);
      last_rd = ref_mem[a];
    end
  endtask
  initial begin
    req = '0;
    we = '0;
    for (int i = 0; i < 3; i++) begin
      a_[i] = '0;
      d_[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wren", bus.ram_wren, 0);
    chk("rst_addr", bus.ram_address, 0);
    chk("rst_data", bus.ram_data, 0);
    for (int i = 0; i < 16; i++) begin
      req = 3'b001;
      we = 3'b001;
      a_[0] = 4'(i);
      d_[0] = $urandom;
      serve(0);
    end
    req = 3'b001;
    we = 3'b001;
    a_[0] = 4'd3;
    d_[0] = 32'hA5A5_0003;
    serve(0);
    req = 3'b100;
    we = 3'b000;
    a_[2] = 4'd3;
    serve(0);
    chk("t2_rdata", bus.rdata, 32'hA5A5_0003);
    @(negedge clk);
    chk("t2_rdata_held", bus.rdata, 32'hA5A5_0003);
    req = 3'b010;
    we = 3'b010;
    a_[1] = 4'd5;
    serve(0);
    we = 3'b000;
    for (int i = 0; i < 3; i++) a_[i] = 4'($urandom);
    req = 3'b111;
    repeat (4) serve(1);
    req = 3'b000;
    req = 3'b010;
    a_[1] = 4'd0;
    for (int i = 0; i < 16; i++) begin
      serve(1);
      a_[1] = 4'(i + 1);
    end
    req = 3'b000;
    req = 3'b100;
    a_[2] = 4'd3;
    @(negedge clk);
    chk("t5a_gnt", bus.gnt, 3'b100);
    req = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5a_busy", bus.busy, 0);
    chk("t5a_rvalid", bus.rvalid, 0);
    rst = 1'b0;
    last = 2;
    last_rd = '0;
    repeat (RD_LAT + 1) begin
      @(negedge clk);
      chk("t5a_no_rvalid", bus.rvalid, 0);
    end
    req = 3'b001;
    we = 3'b001;
    a_[0] = 4'd7;
    d_[0] = 32'hDEAD_0007;
    @(negedge clk);
    chk("t5b_gnt", bus.gnt, 3'b001);
    rst = 1'b1;
    req = 3'b000;
    #1;
    chk("t5b_wren_gated", bus.ram_wren, 0);
    @(negedge clk);
    rst = 1'b0;
    last = 2;
    last_rd = '0;
    we = 3'b000;
    req = 3'b100;
    a_[2] = 4'd7;
    serve(0);
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 3; p++) if (!req[p] && $urandom_range(0, 1) == 1) begin
        req[p] = 1'b1;
        we[p] = 1'($urandom);
        a_[p] = 4'($urandom);
        d_[p] = $urandom;
      end
      if (req == 3'b000) begin
        req[0] = 1'b1;
        we[0] = 1'($urandom);
        a_[0] = 4'($urandom);
        d_[0] = $urandom;
      end
      serve(0);
    end
    while (req != 3'b000) serve(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
